// File: rtl/measure_frontend.sv
// measure_frontend: measurement-side responder for the secant current controller.
// Loads i_ref into the DAC, waits SETTLE_CYCLES, averages 2^AVG_LOG2 ADC
// conversions and publishes q_measured with a one-cycle ready pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            run measurements while high; low aborts to IDLE
//   i_ref             requested current code (captured when entering LOAD)
//   dac_code/dac_load DAC code and one-cycle load strobe
//   adc_start         one-cycle conversion request
//   adc_valid/adc_data ADC result strobe and data
//   q_measured/ready  averaged result (held) and one-cycle publish pulse
//   timeout           sticky ADC watchdog fault
//
// Optional feature: define MEAS_TIMEOUT_EN to enable the ADC watchdog.
module measure_frontend #(
    parameter int unsigned BUS_WIDTH      = 10,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    output logic [BUS_WIDTH-1:0] dac_code,
    output logic                 dac_load,
    output logic                 adc_start,
    input  logic                 adc_valid,
    input  logic [BUS_WIDTH-1:0] adc_data,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 timeout
);

    localparam int unsigned ACC_W  = BUS_WIDTH + AVG_LOG2;
    localparam int unsigned NSAMP  = 1 << AVG_LOG2;
    localparam int unsigned SAMP_W = AVG_LOG2 + 1;
    localparam int unsigned SCNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CONVERT,
        WAIT_ADC,
        PUBLISH
    } state_t;

    state_t                state_q, state_d;
    logic [SCNT_W-1:0]     settle_cnt_q, settle_cnt_d;
    logic [SAMP_W-1:0]     samp_cnt_q, samp_cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]      acc_sum;
    logic [BUS_WIDTH-1:0]  dac_code_q, dac_code_d;
    logic [BUS_WIDTH-1:0]  q_meas_q, q_meas_d;
    logic                  dac_load_q, dac_load_d;
    logic                  adc_start_q, adc_start_d;
    logic                  ready_q, ready_d;

`ifdef MEAS_TIMEOUT_EN
    localparam int unsigned TMO_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TMO_W   = (TMO_RAW < 8) ? 8 : TMO_RAW;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    assign acc_sum = acc_q + ACC_W'(adc_data);

    // Next-state and registered-output logic; strobes are decoded from the
    // next state so they line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        acc_d        = acc_q;
        dac_code_d   = dac_code_q;
        q_meas_d     = q_meas_q;
`ifdef MEAS_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (enable) state_d = LOAD;
            end
            LOAD: begin
                state_d      = SETTLE;
                settle_cnt_d = '0;
            end
            SETTLE: begin
                if (settle_cnt_q == SCNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = CONVERT;
                end else begin
                    settle_cnt_d = settle_cnt_q + SCNT_W'(1);
                end
            end
            CONVERT: begin
                state_d = WAIT_ADC;
`ifdef MEAS_TIMEOUT_EN
                tmo_cnt_d = TMO_W'(1);
`endif
            end
            WAIT_ADC: begin
                if (adc_valid) begin
                    acc_d      = acc_sum;
                    samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                    if (samp_cnt_q == SAMP_W'(NSAMP - 1)) begin
                        state_d  = PUBLISH;
                        q_meas_d = BUS_WIDTH'(acc_sum >> AVG_LOG2);
                    end else begin
                        state_d = CONVERT;
                    end
`ifdef MEAS_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // ADC never answered: flag it and restart the measurement.
                    timeout_d = 1'b1;
                    state_d   = LOAD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end
            PUBLISH: begin
                state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase

        // Abort: drop the partial measurement, keep dac_code and q_measured.
        if (state_q != IDLE && !enable) begin
            state_d    = IDLE;
            acc_d      = '0;
            samp_cnt_d = '0;
            q_meas_d   = q_meas_q;
        end

        // Entering LOAD captures i_ref and starts a fresh average.
        if (state_d == LOAD) begin
            dac_code_d = i_ref;
            acc_d      = '0;
            samp_cnt_d = '0;
        end

        dac_load_d  = (state_d == LOAD);
        adc_start_d = (state_d == CONVERT);
        ready_d     = (state_d == PUBLISH);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            acc_q        <= '0;
            dac_code_q   <= '0;
            q_meas_q     <= '0;
            dac_load_q   <= 1'b0;
            adc_start_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            acc_q        <= acc_d;
            dac_code_q   <= dac_code_d;
            q_meas_q     <= q_meas_d;
            dac_load_q   <= dac_load_d;
            adc_start_q  <= adc_start_d;
            ready_q      <= ready_d;
        end
    end

`ifdef MEAS_TIMEOUT_EN
    // Watchdog counter and sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign dac_code   = dac_code_q;
    assign dac_load   = dac_load_q;
    assign adc_start  = adc_start_q;
    assign q_measured = q_meas_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_measure_frontend.sv
// Directed testbench for measure_frontend (default parameters plus an
// AVG_LOG2=0 instance). Inputs change and outputs are sampled on the falling
// edge; cyc counts rising edges.
module tb_measure_frontend;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] i_ref = '0;
    logic       adc_valid = 1'b0;
    logic [9:0] adc_data = '0;
    logic [9:0] dac_code, q_measured;
    logic       dac_load, adc_start, ready, timeout;

    logic       en0 = 1'b0;
    logic [9:0] iref0 = '0;
    logic       adc_valid0 = 1'b0;
    logic [9:0] adc_data0 = '0;
    logic [9:0] dac_code0, q_measured0;
    logic       dac_load0, adc_start0, ready0, timeout0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int last_tr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    measure_frontend dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .i_ref(i_ref),
        .dac_code(dac_code), .dac_load(dac_load), .adc_start(adc_start),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .q_measured(q_measured), .ready(ready), .timeout(timeout)
    );

    measure_frontend #(.AVG_LOG2(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en0), .i_ref(iref0),
        .dac_code(dac_code0), .dac_load(dac_load0), .adc_start(adc_start0),
        .adc_valid(adc_valid0), .adc_data(adc_data0),
        .q_measured(q_measured0), .ready(ready0), .timeout(timeout0)
    );

    function automatic logic sig_of(input int w);
        case (w)
            0: return dac_load;
            1: return adc_start;
            2: return ready;
            3: return dac_load0;
            4: return adc_start0;
            5: return ready0;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait (checks the current falling edge first); t = -1 on expiry.
    task automatic wait_sig(input int which, input int limit, output int t);
        t = -1;
        for (int n = 0; n < limit; n++) begin
            if (sig_of(which)) begin
                t = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    // One full default-parameter measurement with an ADC answering at k=1.
    task automatic measure(input logic [9:0] s0, s1, s2, s3,
                           input logic [9:0] exp_code, exp_q,
                           input bit stray, input int new_ref,
                           output int t0, output int tr);
        logic [9:0] s [4];
        int ts;
        s = '{s0, s1, s2, s3};
        tr = -1;
        wait_sig(0, 200, t0);
        checks++;
        if (t0 < 0) begin
            errors++; $display("FAIL dac_load_wait: no dac_load within 200 cycles");
            return;
        end
        checks++;
        if (dac_code !== exp_code) begin
            errors++; $display("FAIL dac_code: got %0d expected %0d", dac_code, exp_code);
        end
        if (stray) begin
            @(negedge clk); adc_valid = 1'b1; adc_data = 10'd1000;
            @(negedge clk); adc_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            wait_sig(1, 200, ts);
            checks++;
            if (ts != t0 + 17 + 2 * i) begin
                errors++; $display("FAIL adc_start_time[%0d]: got %0d expected %0d", i, ts, t0 + 17 + 2 * i);
                if (ts < 0) return;
            end
            @(negedge clk); adc_valid = 1'b1; adc_data = s[i];
            if (i == 1 && new_ref >= 0) i_ref = 10'(new_ref);
            @(negedge clk); adc_valid = 1'b0;
        end
        wait_sig(2, 50, tr);
        checks++;
        if (tr != t0 + 25) begin
            errors++; $display("FAIL ready_time: got %0d expected %0d", tr, t0 + 25);
        end
        checks++;
        if (q_measured !== exp_q) begin
            errors++; $display("FAIL q_measured: got %0d expected %0d", q_measured, exp_q);
        end
    endtask

    task automatic test_reset();
        bit bad;
        rst_n = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dac_code, q_measured, dac_load, adc_start, ready, timeout} !== 24'd0) begin
            errors++; $display("FAIL reset_values: got %h expected 0",
                               {dac_code, q_measured, dac_load, adc_start, ready, timeout});
        end
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (dac_load || adc_start || ready) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL idle_quiet: got activity expected none with enable low");
        end
    endtask

    task automatic test_avg0();
        int t0, ts, tr;
        iref0 = 10'd77; en0 = 1'b1;
        wait_sig(3, 20, t0);
        checks++;
        if (t0 < 0 || dac_code0 !== 10'd77) begin
            errors++; $display("FAIL avg0_load: got t0=%0d code=%0d expected code 77", t0, dac_code0);
        end
        wait_sig(4, 40, ts);
        checks++;
        if (ts != t0 + 17) begin
            errors++; $display("FAIL avg0_start: got %0d expected %0d", ts, t0 + 17);
        end
        @(negedge clk); adc_valid0 = 1'b1; adc_data0 = 10'd777;
        @(negedge clk); adc_valid0 = 1'b0;
        wait_sig(5, 10, tr);
        checks++;
        if (tr != t0 + 19 || q_measured0 !== 10'd777) begin
            errors++; $display("FAIL avg0_result: got t=%0d q=%0d expected t=%0d q=777", tr, q_measured0, t0 + 19);
        end
        en0 = 1'b0;
    endtask

    task automatic test_basic();
        int t0, tr;
        i_ref = 10'd512; enable = 1'b1;
        measure(10'd300, 10'd302, 10'd304, 10'd306, 10'd512, 10'd303, 1'b1, -1, t0, tr);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || dac_load !== 1'b1 || q_measured !== 10'd303) begin
            errors++; $display("FAIL after_ready: got ready=%b load=%b q=%0d expected 0 1 303",
                               ready, dac_load, q_measured);
        end
        last_tr = tr;
    endtask

    task automatic test_back_to_back();
        int t0, tr;
        measure(10'd1023, 10'd1023, 10'd1023, 10'd1022, 10'd512, 10'd1022, 1'b0, -1, t0, tr);
        checks++;
        if (t0 != last_tr + 1) begin
            errors++; $display("FAIL next_load_time: got %0d expected %0d", t0, last_tr + 1);
        end
        last_tr = tr;
    endtask

    task automatic test_late_iref();
        int t0, tr;
        measure(10'd500, 10'd500, 10'd501, 10'd501, 10'd512, 10'd500, 1'b0, 100, t0, tr);
        measure(10'd10, 10'd20, 10'd30, 10'd41, 10'd100, 10'd25, 1'b0, -1, t0, tr);
        last_tr = tr;
    endtask

    task automatic test_abort();
        int t0, te, tr;
        bit bad;
        wait_sig(0, 10, t0);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (adc_start || ready || dac_load) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL abort_quiet: got strobe activity expected none");
        end
        checks++;
        if (q_measured !== 10'd25 || dac_code !== 10'd100) begin
            errors++; $display("FAIL abort_hold: got q=%0d code=%0d expected 25 100", q_measured, dac_code);
        end
        i_ref = 10'd200; enable = 1'b1; te = cyc;
        measure(10'd400, 10'd401, 10'd402, 10'd403, 10'd200, 10'd401, 1'b0, -1, t0, tr);
        checks++;
        if (t0 != te + 1) begin
            errors++; $display("FAIL reenable_load: got %0d expected %0d", t0, te + 1);
        end
    endtask

    task automatic test_async_reset();
        int ts, trel, t;
        wait_sig(1, 60, ts);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dac_code, q_measured, dac_load, adc_start, ready, timeout} !== 24'd0) begin
            errors++; $display("FAIL async_reset: got %h expected 0",
                               {dac_code, q_measured, dac_load, adc_start, ready, timeout});
        end
        @(negedge clk);
        rst_n = 1'b1; trel = cyc;
        wait_sig(0, 5, t);
        checks++;
        if (t != trel + 1) begin
            errors++; $display("FAIL post_reset_load: got %0d expected %0d", t, trel + 1);
        end
    endtask

    task automatic test_timeout();
        int ts;
        bit bad;
        wait_sig(1, 40, ts);
        bad = 1'b0;
`ifdef MEAS_TIMEOUT_EN
        begin
            int tt;
            tt = -1;
            for (int n = 0; n < 300 && tt < 0; n++) begin
                @(negedge clk);
                if (ready) bad = 1'b1;
                if (timeout) tt = cyc;
            end
            checks++;
            if (tt != ts + 255) begin
                errors++; $display("FAIL timeout_time: got %0d expected %0d", tt, ts + 255);
            end
            checks++;
            if (dac_load !== 1'b1) begin
                errors++; $display("FAIL timeout_reload: got dac_load=%b expected 1", dac_load);
            end
            repeat (20) begin
                @(negedge clk);
                if (ready || !timeout) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++; $display("FAIL timeout_sticky: got ready pulse or timeout drop expected neither");
            end
        end
`else
        repeat (300) begin
            @(negedge clk);
            if (ready || adc_start || dac_load || timeout) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL wait_forever: got activity or timeout expected FSM parked in WAIT_ADC");
        end
`endif
    endtask

    initial begin
        test_reset();
        test_avg0();
        test_basic();
        test_back_to_back();
        test_late_iref();
        test_abort();
        test_async_reset();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/measure_frontend.md
# measure_frontend

Measurement-side responder for the secant current controller. It accepts the controller's `i_ref` code, loads it into the current DAC and waits a fixed settle time. It then runs 2^AVG_LOG2 ADC conversions, averages them, and publishes `q_measured` with a one-cycle `ready` pulse. It sits between the control loop and the analog DAC/ADC macros and free-runs while enabled, re-sampling `i_ref` after every publish.

## Interface
- `BUS_WIDTH`, 10: width of `i_ref`, DAC code, ADC data and `q_measured`.
- `SETTLE_CYCLES`, 16: cycles waited after `dac_load` before first conversion (≥1).
- `AVG_LOG2`, 2: log2 of samples averaged per measurement (0..4).
- `TIMEOUT_CYCLES`, 255: ADC watchdog limit (used only with `MEAS_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: run measurements while high.
- `i_ref` in BUS_WIDTH: requested current code from the controller.
- `dac_code` out BUS_WIDTH: code driven to the DAC.
- `dac_load` out 1: one-cycle strobe; `dac_code` is valid in that cycle.
- `adc_start` out 1: one-cycle conversion request.
- `adc_valid` in 1: one-cycle strobe; `adc_data` is valid in that cycle.
- `adc_data` in BUS_WIDTH: unsigned conversion result.
- `q_measured` out BUS_WIDTH: averaged result, held between publishes.
- `ready` out 1: one-cycle pulse; `q_measured` is new in that cycle.
- `timeout` out 1: sticky ADC watchdog fault.

## Operation
- States and transitions:
  - IDLE: → LOAD when `enable`.
  - LOAD: `dac_code` ← `i_ref`, `dac_load`=1, clear accumulator and sample count; → SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles; → CONVERT.
  - CONVERT: `adc_start`=1; → WAIT_ADC.
  - WAIT_ADC: on `adc_valid`, add `adc_data` to the accumulator and increment the count. If the count reaches 2^AVG_LOG2 → PUBLISH, else → CONVERT.
  - PUBLISH: `q_measured` = accumulator >> AVG_LOG2, `ready`=1; → LOAD.
- Accumulator is BUS_WIDTH+AVG_LOG2 bits unsigned and cannot overflow. The average truncates (floor); there is no rounding.
- `i_ref` is sampled only in LOAD. Changes at any other time affect the next measurement only.
- `adc_valid` outside WAIT_ADC is ignored, including a strobe coincident with `adc_start`.
- `enable` low in any non-IDLE state aborts to IDLE next cycle:
  - accumulator cleared, no `ready`;
  - `dac_code` and `q_measured` hold their values.
- `rst_n` low at any time asynchronously forces IDLE. Reset values: `dac_code`=0, `dac_load`=0, `adc_start`=0, `q_measured`=0, `ready`=0, `timeout`=0, accumulator=0.

## Timing
- All outputs are registered. Strobes are high for exactly one cycle.
- Let LOAD be at cycle t0 and let the ADC answer k≥1 cycles after `adc_start`:
  - SETTLE occupies t0+1..t0+SETTLE_CYCLES;
  - first `adc_start` at t0+SETTLE_CYCLES+1;
  - each sample takes k+1 cycles;
  - `ready` at t0+SETTLE_CYCLES+2^AVG_LOG2·(k+1)+1;
  - next `dac_load` one cycle after `ready`.
- With defaults and k=1: `ready` at t0+25, next LOAD at t0+26.
- Controller handshake: `ready` is a pulse, not a level. A consumer samples `q_measured` in the `ready` cycle or any later cycle before the next pulse.

## Configuration
- `MEAS_TIMEOUT_EN` defined:
  - An 8+ bit counter runs in WAIT_ADC.
  - If `adc_valid` has not arrived TIMEOUT_CYCLES cycles after `adc_start`, `timeout` is set (sticky until reset) and the FSM goes to LOAD.
  - The measurement restarts with a fresh `i_ref` sample and no `ready`.
- Not defined: WAIT_ADC waits indefinitely, `timeout` is tied 0, and no counter logic is present.

## Test plan
- Basic: `i_ref`=512, defaults, k=1, samples 300/302/304/306 → `dac_load` with `dac_code`=512 at t0, `adc_start` at t0+17/19/21/23, `ready` at t0+25 with `q_measured`=303.
- Truncation: samples 1023/1023/1023/1022 → `q_measured`=1022; AVG_LOG2=0 with sample 777 → `q_measured`=777.
- Abort: drop `enable` during SETTLE → no `adc_start`, no `ready`, `q_measured` keeps 303. Re-enable with `i_ref`=200 → `dac_load` with 200 one cycle after IDLE exit.
- Late `i_ref`: change 512→100 during WAIT_ADC → published result is computed from the 512 measurement; following `dac_load` carries 100. A stray `adc_valid` in SETTLE leaves the accumulator unchanged.
- Timeout (macro on): never assert `adc_valid` → `timeout`=1 exactly 255 cycles after `adc_start`, new `dac_load` follows, `ready` stays 0, `timeout` stays 1. Macro off: FSM stays in WAIT_ADC and `timeout`=0.
- Reset: assert `rst_n`=0 mid-CONVERT asynchronously → all outputs 0 before the next edge. After release, LOAD occurs on the first edge with `enable`=1.
